// File: rtl/breadboard_sweep_ctrl.sv
// rtl/breadboard_sweep_ctrl.sv - 16-row sweep sequencer for the Breadboard block; optional output MISR under SWEEP_SIGNATURE_EN
module breadboard_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic [9:0]  f,
    output logic [3:0]  exp_addr,
    input  logic [9:0]  exp_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_cnt,
    output logic [3:0]  first_fail,
    output logic        first_fail_vld
`ifdef SWEEP_SIGNATURE_EN
    ,
    output logic [15:0] sig
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Last settle count before the row is sampled
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  fail_cnt_q, fail_cnt_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        first_fail_vld_q, first_fail_vld_d;
    logic        pass_q, pass_d;
    logic        mismatch;

    assign mismatch = (f != exp_data);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: settle for SETTLE cycles, sample once, advance until row 15
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (row_q == 4'hF) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state only
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SETTLE: busy = 1'b1;
            ST_SAMPLE: busy = 1'b1;
            ST_DONE:   done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next values: row stepping, settle counter and result bookkeeping
    always_comb begin
        row_d            = row_q;
        cnt_d            = cnt_q;
        fail_cnt_d       = fail_cnt_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;
        pass_d           = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d            = 4'd0;
                    cnt_d            = 4'd0;
                    fail_cnt_d       = 5'd0;
                    first_fail_d     = 4'd0;
                    first_fail_vld_d = 1'b0;
                    pass_d           = 1'b0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_cnt_d = fail_cnt_q + 5'd1;
                    if (!first_fail_vld_q) begin
                        first_fail_d     = row_q;
                        first_fail_vld_d = 1'b1;
                    end
                end
                cnt_d = 4'd0;
                // Row 15 is kept after the sweep so the last vector stays applied
                if (row_q != 4'hF) begin
                    row_d = row_q + 4'd1;
                end
            end
            ST_DONE: begin
                pass_d = (fail_cnt_q == 5'd0);
            end
            default: begin
                row_d = row_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q            <= 4'd0;
            cnt_q            <= 4'd0;
            fail_cnt_q       <= 5'd0;
            first_fail_q     <= 4'd0;
            first_fail_vld_q <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            row_q            <= row_d;
            cnt_q            <= cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
            pass_q           <= pass_d;
        end
    end

`ifdef SWEEP_SIGNATURE_EN
    logic [15:0] sig_q, sig_d;

    // MISR next value: seeded on start, folds in the raw Breadboard outputs each SAMPLE
    always_comb begin
        sig_d = sig_q;
        if (state_q == ST_IDLE && start) begin
            sig_d = 16'hFFFF;
        end else if (state_q == ST_SAMPLE) begin
            sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ {6'b0, f};
        end
    end

    // MISR register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

    // The row register drives the Breadboard and the golden ROM with no decode
    assign {w, x, y, z}    = row_q;
    assign exp_addr        = row_q;
    assign pass            = pass_q;
    assign fail_cnt        = fail_cnt_q;
    assign first_fail      = first_fail_q;
    assign first_fail_vld  = first_fail_vld_q;

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// tb/tb_breadboard_sweep_ctrl.sv - randomized self-checking bench for breadboard_sweep_ctrl
module tb_breadboard_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;

    logic        w_a, x_a, y_a, z_a, w_b, x_b, y_b, z_b;
    logic [9:0]  f_a, f_b, exp_data_a, exp_data_b;
    logic [3:0]  exp_addr_a, exp_addr_b;
    logic        busy_a, done_a, pass_a, ffv_a;
    logic        busy_b, done_b, pass_b, ffv_b;
    logic [4:0]  fcnt_a, fcnt_b;
    logic [3:0]  ff_a, ff_b;
    logic [15:0] sig_a, sig_b;

    // Breadboard stand-in (random truth table) and golden ROM
    logic [9:0]  bb_tab [16];
    logic [9:0]  gold_tab [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign f_a        = bb_tab[{w_a, x_a, y_a, z_a}];
    assign f_b        = bb_tab[{w_b, x_b, y_b, z_b}];
    assign exp_data_a = gold_tab[exp_addr_a];
    assign exp_data_b = gold_tab[exp_addr_b];

    breadboard_sweep_ctrl #(.SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .w(w_a), .x(x_a), .y(y_a), .z(z_a), .f(f_a),
        .exp_addr(exp_addr_a), .exp_data(exp_data_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_cnt(fcnt_a),
        .first_fail(ff_a), .first_fail_vld(ffv_a)
`ifdef SWEEP_SIGNATURE_EN
        , .sig(sig_a)
`endif
    );

    breadboard_sweep_ctrl #(.SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .w(w_b), .x(x_b), .y(y_b), .z(z_b), .f(f_b),
        .exp_addr(exp_addr_b), .exp_data(exp_data_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_cnt(fcnt_b),
        .first_fail(ff_b), .first_fail_vld(ffv_b)
`ifdef SWEEP_SIGNATURE_EN
        , .sig(sig_b)
`endif
    );

`ifndef SWEEP_SIGNATURE_EN
    assign sig_a = 16'h0000;
    assign sig_b = 16'h0000;
`endif

    // Reference model: whole-sweep results straight from the tables
    function automatic void model(output int fc, output int ff, output bit vld, output logic [15:0] s);
        fc = 0; ff = 0; vld = 1'b0; s = 16'hFFFF;
        for (int r = 0; r < 16; r++) begin
            if (bb_tab[r] != gold_tab[r]) begin
                if (!vld) begin ff = r; vld = 1'b1; end
                fc++;
            end
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {6'b0, bb_tab[r]};
        end
    endfunction

    task automatic new_tables();
        for (int r = 0; r < 16; r++) begin
            bb_tab[r]   = 10'($urandom);
            gold_tab[r] = bb_tab[r];
        end
    endtask

    // Start a sweep on dut_a and watch up to 60 cycles; lat = cycles from E0 to done (-1 if never)
    task automatic sweep_a(output int lat, output int npulse);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        lat = -1; npulse = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done_a) begin
                npulse++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy_a, done_a); end
        checks++; if (pass_a !== 1'b0 || ffv_a !== 1'b0) begin errors++; $display("FAIL reset_pass_vld: got %b%b want 00", pass_a, ffv_a); end
        checks++; if (fcnt_a !== 5'd0 || ff_a !== 4'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", fcnt_a, ff_a); end
        checks++; if ({w_a, x_a, y_a, z_a} !== 4'd0 || exp_addr_a !== 4'd0) begin errors++; $display("FAIL reset_row: got %b/%0d want 0", {w_a, x_a, y_a, z_a}, exp_addr_a); end
        checks++; if (busy_b !== 1'b0 || fcnt_b !== 5'd0) begin errors++; $display("FAIL reset_b: got busy %b cnt %0d want 0", busy_b, fcnt_b); end
`ifdef SWEEP_SIGNATURE_EN
        checks++; if (sig_a !== 16'h0) begin errors++; $display("FAIL reset_sig: got %h want 0000", sig_a); end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_golden_pass();
        int lat, np, efc, eff; bit evld; logic [15:0] es;
        new_tables();
        model(efc, eff, evld, es);
        sweep_a(lat, np);
        checks++; if (lat != 48) begin errors++; $display("FAIL golden_latency: got %0d want 48", lat); end
        checks++; if (np != 1) begin errors++; $display("FAIL golden_pulses: got %0d want 1", np); end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL golden_pass: got %b want 1", pass_a); end
        checks++; if (fcnt_a !== 5'd0 || ffv_a !== 1'b0) begin errors++; $display("FAIL golden_fail: got cnt %0d vld %b want 0 0", fcnt_a, ffv_a); end
        checks++; if (busy_a !== 1'b0 || exp_addr_a !== 4'd15) begin errors++; $display("FAIL golden_idle: got busy %b row %0d want 0 15", busy_a, exp_addr_a); end
    endtask

    task automatic test_fault_inject();
        int lat, np, efc, eff; bit evld; logic [15:0] es;
        new_tables();
        gold_tab[5]  = gold_tab[5]  ^ 10'h008;
        gold_tab[12] = gold_tab[12] ^ 10'h008;
        model(efc, eff, evld, es);
        sweep_a(lat, np);
        checks++; if (lat != 48 || np != 1) begin errors++; $display("FAIL fault_done: got lat %0d pulses %0d want 48 1", lat, np); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL fault_pass: got %b want 0", pass_a); end
        checks++; if (fcnt_a !== 5'd2) begin errors++; $display("FAIL fault_cnt: got %0d want 2", fcnt_a); end
        checks++; if (ff_a !== 4'd5 || ffv_a !== 1'b1) begin errors++; $display("FAIL fault_first: got %0d vld %b want 5 1", ff_a, ffv_a); end
`ifdef SWEEP_SIGNATURE_EN
        checks++; if (sig_a !== es) begin errors++; $display("FAIL fault_rom_sig: got %h want %h", sig_a, es); end
`endif
    endtask

    task automatic test_random_faults();
        int lat, np, efc, eff; bit evld; logic [15:0] es;
        for (int it = 0; it < 6; it++) begin
            new_tables();
            for (int r = 0; r < 16; r++) begin
                if ($urandom_range(0, 3) == 0) gold_tab[r] = gold_tab[r] ^ (10'd1 << $urandom_range(0, 9));
            end
            if (it == 5) begin
                for (int r = 0; r < 16; r++) gold_tab[r] = ~bb_tab[r];
            end
            model(efc, eff, evld, es);
            sweep_a(lat, np);
            checks++; if (lat != 48 || np != 1) begin errors++; $display("FAIL rand_done[%0d]: got lat %0d pulses %0d want 48 1", it, lat, np); end
            checks++; if (fcnt_a !== 5'(efc) || pass_a !== (efc == 0)) begin errors++; $display("FAIL rand_cnt[%0d]: got cnt %0d pass %b want %0d %b", it, fcnt_a, pass_a, efc, efc == 0); end
            checks++; if (ffv_a !== evld || (evld && ff_a !== 4'(eff))) begin errors++; $display("FAIL rand_first[%0d]: got %0d vld %b want %0d %b", it, ff_a, ffv_a, eff, evld); end
`ifdef SWEEP_SIGNATURE_EN
            checks++; if (sig_a !== es) begin errors++; $display("FAIL rand_sig[%0d]: got %h want %h", it, sig_a, es); end
`endif
        end
    endtask

    task automatic test_vector_order();
        int lat, np, bad;
        new_tables();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        lat = -1; np = 0; bad = 0;
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (j < 32 && {w_b, x_b, y_b, z_b} !== 4'(j / 2)) begin
                bad++;
                $display("FAIL vec_order: cycle %0d got %0d want %0d", j, {w_b, x_b, y_b, z_b}, j / 2);
            end
            if (done_b) begin np++; if (lat < 0) lat = j; end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL vec_order_total: got %0d bad cycles want 0", bad); end
        checks++; if (lat != 32 || np != 1) begin errors++; $display("FAIL vec_done: got lat %0d pulses %0d want 32 1", lat, np); end
        checks++; if (pass_b !== 1'b1 || fcnt_b !== 5'd0) begin errors++; $display("FAIL vec_result: got pass %b cnt %0d want 1 0", pass_b, fcnt_b); end
    endtask

    task automatic test_start_while_busy();
        int lat, np, efc, eff; bit evld, hit7; logic [15:0] es;
        new_tables();
        gold_tab[5]  = gold_tab[5]  ^ 10'h008;
        gold_tab[12] = gold_tab[12] ^ 10'h008;
        model(efc, eff, evld, es);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        lat = -1; np = 0; hit7 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (busy_a && exp_addr_a == 4'd7 && !hit7) begin start_a = 1'b1; hit7 = 1'b1; end
            if (done_a) begin np++; if (lat < 0) lat = k; start_a = 1'b1; end
        end
        start_a = 1'b0;
        checks++; if (lat != 48 || np != 1) begin errors++; $display("FAIL busy_start_done: got lat %0d pulses %0d want 48 1", lat, np); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_start_restart: got busy %b want 0", busy_a); end
        checks++; if (fcnt_a !== 5'(efc) || ff_a !== 4'(eff) || ffv_a !== evld) begin errors++; $display("FAIL busy_start_result: got %0d/%0d/%b want %0d/%0d/%b", fcnt_a, ff_a, ffv_a, efc, eff, evld); end
    endtask

    task automatic test_reset_mid_sweep();
        int lat, np, seen;
        new_tables();
        gold_tab[5] = gold_tab[5] ^ 10'h008;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        seen = 0;
        for (int k = 0; k < 100 && seen == 0; k++) begin
            @(posedge clk); #1;
            if (exp_addr_a == 4'd9) seen = 1;
        end
        checks++; if (seen == 0 || fcnt_a !== 5'd1) begin errors++; $display("FAIL rst_mid_pre: got reached %0d cnt %0d want 1 1", seen, fcnt_a); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy_a !== 1'b0 || fcnt_a !== 5'd0 || ffv_a !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: got busy %b cnt %0d vld %b want 0 0 0", busy_a, fcnt_a, ffv_a); end
        checks++; if ({w_a, x_a, y_a, z_a} !== 4'd0 || done_a !== 1'b0) begin errors++; $display("FAIL rst_mid_row: got %0d done %b want 0 0", {w_a, x_a, y_a, z_a}, done_a); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        np = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) np++;
        end
        checks++; if (np != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", np); end
        for (int r = 0; r < 16; r++) gold_tab[r] = bb_tab[r];
        sweep_a(lat, np);
        checks++; if (lat != 48 || np != 1 || pass_a !== 1'b1 || fcnt_a !== 5'd0) begin errors++; $display("FAIL rst_mid_after: got lat %0d pulses %0d pass %b cnt %0d want 48 1 1 0", lat, np, pass_a, fcnt_a); end
    endtask

    // Two back-to-back golden sweeps (second start at the earliest legal edge), then a Breadboard fault run
    task automatic test_back_to_back();
        int lat1, lat2, lat3, np, efc, eff; bit evld; logic [15:0] es, s1, s2;
        new_tables();
        model(efc, eff, evld, es);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        lat1 = -1;
        for (int k = 1; k <= 60 && lat1 < 0; k++) begin
            @(posedge clk); #1;
            if (done_a) lat1 = k;
        end
        @(posedge clk); #1;
        s1 = sig_a;
        checks++; if (lat1 != 48 || pass_a !== 1'b1) begin errors++; $display("FAIL b2b_first: got lat %0d pass %b want 48 1", lat1, pass_a); end
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", busy_a); end
        lat2 = -1;
        for (int k = 1; k <= 60 && lat2 < 0; k++) begin
            @(posedge clk); #1;
            if (done_a) lat2 = k;
        end
        @(posedge clk); #1;
        s2 = sig_a;
        checks++; if (lat2 != 48 || pass_a !== 1'b1 || fcnt_a !== 5'd0) begin errors++; $display("FAIL b2b_second: got lat %0d pass %b cnt %0d want 48 1 0", lat2, pass_a, fcnt_a); end
`ifdef SWEEP_SIGNATURE_EN
        checks++; if (s1 !== s2 || s1 === 16'h0 || s1 !== es) begin errors++; $display("FAIL b2b_sig: got %h/%h want %h nonzero", s1, s2, es); end
`endif
        bb_tab[5]  = bb_tab[5]  ^ 10'h008;
        bb_tab[12] = bb_tab[12] ^ 10'h008;
        model(efc, eff, evld, es);
        sweep_a(lat3, np);
        checks++; if (fcnt_a !== 5'd2 || ff_a !== 4'd5 || pass_a !== 1'b0) begin errors++; $display("FAIL b2b_fault: got cnt %0d first %0d pass %b want 2 5 0", fcnt_a, ff_a, pass_a); end
`ifdef SWEEP_SIGNATURE_EN
        checks++; if (sig_a === s1 || sig_a !== es) begin errors++; $display("FAIL b2b_fault_sig: got %h golden %h want %h", sig_a, s1, es); end
`endif
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            bb_tab[r]   = 10'd0;
            gold_tab[r] = 10'd0;
        end
        test_reset();
        test_golden_pass();
        test_fault_inject();
        test_random_faults();
        test_vector_order();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
